// File: rtl/memory_access_stage_if.sv
// Data-memory bus between the memory access stage and the data memory.
//
// Signals:
//   dmem_req   - access request, held until the ack cycle
//   dmem_we    - 1 = store, 0 = load
//   dmem_addr  - word-aligned address (bits [1:0] always 00)
//   dmem_wdata - store data, already replicated into the byte lanes
//   dmem_be    - byte-lane enables (0000 for loads)
//   dmem_rdata - load data, valid in the ack cycle
//   dmem_ack   - memory completes the access in this cycle
//
// Modports: master (the pipeline stage) and slave (the memory).
interface memory_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/memory_access_stage.sv
// Memory access stage of a 5-stage RISC-V pipeline: formats stores, issues
// data-memory requests, waits for a variable-latency ack, formats loads, and
// holds the MEM/WB register.
//
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   dmem                - data-memory bus (master side)
//   RegWriteM .. RDM    - control and data from the EX/MEM register
//   RegWriteW .. RDW    - MEM/WB register outputs
//   StallM              - freezes F/D/E and EX/MEM while memory is busy
//   MisalignW,
//   MisalignAddrW       - one-cycle misaligned-access pulse and its address
//                         (present only with MISALIGN_TRAP_EN)
//
// Configuration macro: MISALIGN_TRAP_EN. When defined, misaligned halfword
// and word accesses issue no request and report through MisalignW instead.
// When undefined, the low address bits are simply ignored as appropriate.
module memory_access_stage (
  input  logic                         clk,
  input  logic                         rst,
  memory_access_stage_if.master        dmem,
  input  logic                         RegWriteM,
  input  logic                         MemWriteM,
  input  logic [1:0]                   ResultSrcM,
  input  logic [2:0]                   Funct3M,
  input  logic [31:0]                  ALUResultM,
  input  logic [31:0]                  WriteDataM,
  input  logic [31:0]                  PCPlus4M,
  input  logic [4:0]                   RDM,
  output logic                         RegWriteW,
  output logic [1:0]                   ResultSrcW,
  output logic [31:0]                  ALUResultW,
  output logic [31:0]                  ReadDataW,
  output logic [31:0]                  PCPlus4W,
  output logic [4:0]                   RDW,
`ifdef MISALIGN_TRAP_EN
  output logic                         MisalignW,
  output logic [31:0]                  MisalignAddrW,
`endif
  output logic                         StallM
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state;
  logic        memop;
  logic        misalign;
  logic        access;
  logic [31:0] rdata_shift;
  logic [15:0] rdata_half;
  logic [31:0] load_data;

  assign memop = MemWriteM | (ResultSrcM == 2'b01);

`ifdef MISALIGN_TRAP_EN
  // Halfword on an odd byte, or word on any non-zero offset.
  assign misalign = memop &
                    (((Funct3M[1:0] == 2'b01) & ALUResultM[0]) |
                     (Funct3M[1] & (ALUResultM[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign access = memop & ~misalign;

  // Gating with rst drops the request in the same cycle reset is asserted,
  // even though the EX/MEM inputs may still present a memory op.
  assign dmem.dmem_req  = rst & (((state == S_IDLE) & access) | (state == S_WAIT));
  assign StallM         = dmem.dmem_req & ~dmem.dmem_ack;
  assign dmem.dmem_addr = {ALUResultM[31:2], 2'b00};
  assign dmem.dmem_we   = MemWriteM;

  // Store formatting: data is replicated into every lane and byte enables
  // select the lane(s) actually written.
  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    dmem.dmem_wdata = '0;
    dmem.dmem_be    = 4'b0000;
    if (MemWriteM) begin
      unique case (Funct3M[1:0])
        2'b00: begin
          dmem.dmem_wdata = {4{WriteDataM[7:0]}};
          dmem.dmem_be    = 4'b0001 << ALUResultM[1:0];
        end
        2'b01: begin
          dmem.dmem_wdata = {2{WriteDataM[15:0]}};
          dmem.dmem_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          dmem.dmem_wdata = WriteDataM;
          dmem.dmem_be    = 4'b1111;
        end
      endcase
    end
  end

  // Load formatting: byte lane picked by addr[1:0], halfword lane by addr[1].
  assign rdata_shift = dmem.dmem_rdata >> {ALUResultM[1:0], 3'b000};
  assign rdata_half  = ALUResultM[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

  always_comb begin
    load_data = dmem.dmem_rdata;
    unique case (Funct3M)
      3'b000:  load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b001:  load_data = {{16{rdata_half[15]}}, rdata_half};
      3'b100:  load_data = {24'h0, rdata_shift[7:0]};
      3'b101:  load_data = {16'h0, rdata_half};
      default: load_data = dmem.dmem_rdata;
    endcase
  end

  // FSM and MEM/WB register. A stalled or trapped cycle loads a bubble:
  // only RegWriteW is cleared, the other W fields keep their old values.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RDW        <= '0;
`ifdef MISALIGN_TRAP_EN
      MisalignW     <= 1'b0;
      MisalignAddrW <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: if (access && !dmem.dmem_ack) state <= S_WAIT;
        S_WAIT: if (dmem.dmem_ack)            state <= S_IDLE;
        default:                              state <= S_IDLE;
      endcase

      if (StallM || misalign) begin
        RegWriteW <= 1'b0;
      end else begin
        RegWriteW  <= RegWriteM;
        ResultSrcW <= ResultSrcM;
        ALUResultW <= ALUResultM;
        ReadDataW  <= load_data;
        PCPlus4W   <= PCPlus4M;
        RDW        <= RDM;
      end

`ifdef MISALIGN_TRAP_EN
      // A misaligned op never stalls, so this is a single-cycle pulse
      // unless the same op is presented again.
      MisalignW     <= misalign;
      MisalignAddrW <= misalign ? ALUResultM : '0;
`endif
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed self-checking bench for memory_access_stage. The bench plays the
// data memory itself, driving dmem_rdata/dmem_ack per vector.
module tb_memory_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RDM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RDW;
  logic        StallM;
`ifdef MISALIGN_TRAP_EN
  logic        MisalignW;
  logic [31:0] MisalignAddrW;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  memory_access_stage_if dmem ();

  memory_access_stage dut (
    .clk        (clk),
    .rst        (rst),
    .dmem       (dmem.master),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .PCPlus4M   (PCPlus4M),
    .RDM        (RDM),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .PCPlus4W   (PCPlus4W),
    .RDW        (RDW),
`ifdef MISALIGN_TRAP_EN
    .MisalignW     (MisalignW),
    .MisalignAddrW (MisalignAddrW),
`endif
    .StallM     (StallM)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic regw, input logic memw, input logic [1:0] rsrc,
                        input logic [2:0] f3, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [4:0] rd);
    RegWriteM  = regw;
    MemWriteM  = memw;
    ResultSrcM = rsrc;
    Funct3M    = f3;
    ALUResultM = alu;
    WriteDataM = wd;
    RDM        = rd;
    PCPlus4M   = alu + 32'h1000;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] exp;
  } ld_vec_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } st_vec_t;

  ld_vec_t ld_tab[5];
  st_vec_t st_tab[4];

  initial begin
    // rdata 0x80FF12F4 for every load vector
    ld_tab[0] = '{3'b100, 32'h401, 32'h0000_0012};  // lbu lane 1
    ld_tab[1] = '{3'b000, 32'h400, 32'hFFFF_FFF4};  // lb lane 0, negative
    ld_tab[2] = '{3'b101, 32'h402, 32'h0000_80FF};  // lhu upper half
    ld_tab[3] = '{3'b001, 32'h400, 32'h0000_12F4};  // lh lower, positive
    ld_tab[4] = '{3'b001, 32'h402, 32'hFFFF_80FF};  // lh upper, negative
    // WriteDataM 0x1234ABCD for every store vector
    st_tab[0] = '{3'b000, 32'h101, 32'hCDCD_CDCD, 4'b0010};
    st_tab[1] = '{3'b000, 32'h103, 32'hCDCD_CDCD, 4'b1000};
    st_tab[2] = '{3'b001, 32'h200, 32'hABCD_ABCD, 4'b0011};
    st_tab[3] = '{3'b010, 32'h204, 32'h1234_ABCD, 4'b1111};

    rst = 1'b0;
    dmem.dmem_rdata = '0;
    dmem.dmem_ack   = 1'b0;
    set_op(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);

    // Reset state
    tick();
    tick();
    check("rst_regwrite",  32'(RegWriteW), 32'd0);
    check("rst_resultsrc", 32'(ResultSrcW), 32'd0);
    check("rst_aluresult", ALUResultW, 32'd0);
    check("rst_readdata",  ReadDataW, 32'd0);
    check("rst_pcplus4",   PCPlus4W, 32'd0);
    check("rst_rd",        32'(RDW), 32'd0);
    check("rst_req",       32'(dmem.dmem_req), 32'd0);
    rst = 1'b1;

    // ALU op: no request, one-cycle pass-through
    set_op(1'b1, 1'b0, 2'b00, 3'b000, 32'd7, 32'h0, 5'd5);
    #2;
    check("alu_req",   32'(dmem.dmem_req), 32'd0);
    check("alu_stall", 32'(StallM), 32'd0);
    tick();
    check("alu_result_w", ALUResultW, 32'd7);
    check("alu_rd_w",     32'(RDW), 32'd5);
    check("alu_regw_w",   32'(RegWriteW), 32'd1);
    check("alu_pc4_w",    PCPlus4W, 32'h1007);

    // Zero-wait lw
    set_op(1'b1, 1'b0, 2'b01, 3'b010, 32'h100, 32'h0, 5'd3);
    dmem.dmem_rdata = 32'hDEAD_BEEF;
    dmem.dmem_ack   = 1'b1;
    #2;
    check("lw_req",   32'(dmem.dmem_req), 32'd1);
    check("lw_stall", 32'(StallM), 32'd0);
    check("lw_addr",  dmem.dmem_addr, 32'h100);
    check("lw_we",    32'(dmem.dmem_we), 32'd0);
    check("lw_be",    32'(dmem.dmem_be), 32'd0);
    check("lw_wdata", dmem.dmem_wdata, 32'd0);
    tick();
    dmem.dmem_ack = 1'b0;
    check("lw_readdata_w", ReadDataW, 32'hDEAD_BEEF);
    check("lw_regw_w",     32'(RegWriteW), 32'd1);
    check("lw_src_w",      32'(ResultSrcW), 32'd1);

    // lb at 0x103 with three wait states
    set_op(1'b1, 1'b0, 2'b01, 3'b000, 32'h103, 32'h0, 5'd7);
    dmem.dmem_rdata = 32'h80FF_FFFF;
    for (int i = 0; i < 3; i++) begin
      #2;
      check($sformatf("lb_stall_%0d", i), 32'(StallM), 32'd1);
      check($sformatf("lb_req_%0d", i),   32'(dmem.dmem_req), 32'd1);
      check($sformatf("lb_addr_%0d", i),  dmem.dmem_addr, 32'h100);
      tick();
      check($sformatf("lb_bubble_%0d", i), 32'(RegWriteW), 32'd0);
      check($sformatf("lb_hold_%0d", i),   ALUResultW, 32'h100);
    end
    dmem.dmem_ack = 1'b1;
    #2;
    check("lb_ack_stall", 32'(StallM), 32'd0);
    tick();
    dmem.dmem_ack = 1'b0;
    check("lb_readdata_w", ReadDataW, 32'hFFFF_FF80);
    check("lb_regw_w",     32'(RegWriteW), 32'd1);
    check("lb_rd_w",       32'(RDW), 32'd7);

    // sh at 0x202 with one wait state
    set_op(1'b0, 1'b1, 2'b00, 3'b001, 32'h202, 32'h1234_ABCD, 5'd0);
    #2;
    check("sh_addr",  dmem.dmem_addr, 32'h200);
    check("sh_wdata", dmem.dmem_wdata, 32'hABCD_ABCD);
    check("sh_be",    32'(dmem.dmem_be), 32'hC);
    check("sh_we",    32'(dmem.dmem_we), 32'd1);
    check("sh_stall", 32'(StallM), 32'd1);
    tick();
    dmem.dmem_ack = 1'b1;
    #2;
    check("sh_wait_addr", dmem.dmem_addr, 32'h200);
    tick();
    dmem.dmem_ack = 1'b0;
    check("sh_regw_w", 32'(RegWriteW), 32'd0);
    check("sh_alu_w",  ALUResultW, 32'h202);

    // Zero-wait store formatting table
    dmem.dmem_ack = 1'b1;
    foreach (st_tab[i]) begin
      set_op(1'b0, 1'b1, 2'b00, st_tab[i].f3, st_tab[i].addr, 32'h1234_ABCD, 5'd0);
      #2;
      check($sformatf("st%0d_wdata", i), dmem.dmem_wdata, st_tab[i].wdata);
      check($sformatf("st%0d_be", i),    32'(dmem.dmem_be), 32'(st_tab[i].be));
      tick();
    end

    // Zero-wait load formatting table
    dmem.dmem_rdata = 32'h80FF_12F4;
    foreach (ld_tab[i]) begin
      set_op(1'b1, 1'b0, 2'b01, ld_tab[i].f3, ld_tab[i].addr, 32'h0, 5'd9);
      tick();
      check($sformatf("ld%0d_data", i), ReadDataW, ld_tab[i].exp);
    end
    dmem.dmem_ack = 1'b0;

    // Reset during WAIT, then a spurious ack
    set_op(1'b1, 1'b0, 2'b01, 3'b010, 32'h300, 32'h0, 5'd4);
    tick();
    check("rw_req_wait", 32'(dmem.dmem_req), 32'd1);
    rst = 1'b0;
    #1;
    check("rw_req_drop", 32'(dmem.dmem_req), 32'd0);
    check("rw_regw_w",   32'(RegWriteW), 32'd0);
    check("rw_alu_w",    ALUResultW, 32'd0);
    check("rw_read_w",   ReadDataW, 32'd0);
    check("rw_rd_w",     32'(RDW), 32'd0);
    set_op(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
    #1;
    rst = 1'b1;
    dmem.dmem_ack = 1'b1;
    #1;
    check("spur_req",   32'(dmem.dmem_req), 32'd0);
    check("spur_stall", 32'(StallM), 32'd0);
    tick();
    dmem.dmem_ack = 1'b0;
    #1;
    check("spur_idle_req", 32'(dmem.dmem_req), 32'd0);
    check("spur_regw_w",   32'(RegWriteW), 32'd0);

    // Misaligned access
    set_op(1'b1, 1'b0, 2'b00, 3'b000, 32'd1, 32'h0, 5'd1);
    tick();
`ifdef MISALIGN_TRAP_EN
    set_op(1'b1, 1'b0, 2'b01, 3'b010, 32'h102, 32'h0, 5'd2);
    #2;
    check("mis_req",   32'(dmem.dmem_req), 32'd0);
    check("mis_stall", 32'(StallM), 32'd0);
    tick();
    check("mis_pulse", 32'(MisalignW), 32'd1);
    check("mis_addr",  MisalignAddrW, 32'h102);
    check("mis_regw",  32'(RegWriteW), 32'd0);
    set_op(1'b1, 1'b0, 2'b00, 3'b000, 32'd2, 32'h0, 5'd1);
    tick();
    check("mis_pulse_end", 32'(MisalignW), 32'd0);
`else
    set_op(1'b0, 1'b1, 2'b00, 3'b010, 32'h102, 32'h1234_ABCD, 5'd0);
    dmem.dmem_ack = 1'b1;
    #2;
    check("mis_req",  32'(dmem.dmem_req), 32'd1);
    check("mis_addr", dmem.dmem_addr, 32'h100);
    check("mis_be",   32'(dmem.dmem_be), 32'hF);
    tick();
    dmem.dmem_ack = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have ports: clk input 1 clock; rst input 1 async active-low reset.
REQ-002 SHALL have ports: RegWriteM, MemWriteM input 1; ResultSrcM input 2 (00 ALU, 01 load, 10 PC+4); Funct3M input 3; ALUResultM, WriteDataM, PCPlus4M input 32; RDM input 5 (all from the Execute-stage EX/MEM register).
REQ-003 SHALL have ports: RegWriteW output 1; ResultSrcW output 2; ALUResultW, ReadDataW, PCPlus4W output 32; RDW output 5; StallM output 1 (freeze F/D/E and EX/MEM).
REQ-004 SHALL have bus ports: dmem_req, dmem_we output 1; dmem_addr output 32 (word-aligned, bits[1:0]=00); dmem_wdata output 32; dmem_be output 4; dmem_rdata input 32; dmem_ack input 1.

Function
REQ-005 SHALL treat memop = MemWriteM | (ResultSrcM==01); non-memop instructions pass to the MEM/WB register with 1-cycle latency and no stall.
REQ-006 SHALL implement FSM IDLE/WAIT: IDLE->WAIT when memop & !dmem_ack; WAIT->IDLE on dmem_ack; IDLE->IDLE when memop & dmem_ack (zero-wait memory).
REQ-007 SHALL drive dmem_req combinationally = (IDLE & memop) | WAIT; dmem_addr, dmem_we, dmem_wdata, dmem_be held stable until the ack cycle.
REQ-008 SHALL drive StallM = dmem_req & !dmem_ack.
REQ-009 SHALL, on each clk edge with StallM=1, load a bubble into MEM/WB (RegWriteW=0, other W outputs unchanged).
REQ-010 SHALL, on the clk edge with StallM=0, load RegWriteM, ResultSrcM, ALUResultM, PCPlus4M, RDM and formatted load data into W outputs.
REQ-011 SHALL format stores by Funct3M[1:0]: 00 sb replicate byte to 4 lanes, be=0001<<addr[1:0]; 01 sh replicate half, be=0011 if addr[1]=0 else 1100; 10/11 sw, be=1111.
REQ-012 SHALL format loads by Funct3M: 000 lb, 001 lh sign-extend; 100 lbu, 101 lhu zero-extend; 010/011/110/111 full word; lane chosen by ALUResultM[1:0].
REQ-013 SHALL drive dmem_we=MemWriteM; dmem_wdata=0 and dmem_be=0000 for loads.
REQ-014 SHALL treat an ack arriving in IDLE with no memop as spurious and ignore it.

Reset
REQ-015 SHALL, while rst=0, force state IDLE, RegWriteW=0, ResultSrcW=00, ALUResultW=ReadDataW=PCPlus4W=0, RDW=0.
REQ-016 SHALL, on reset during WAIT, drop dmem_req in the same cycle (async) and discard the pending access; a later ack is ignored per REQ-014.

Configuration
REQ-017 SHALL support macro MISALIGN_TRAP_EN.
REQ-018 Without MISALIGN_TRAP_EN: misaligned addresses are not detected; sh uses addr[1] only, sw ignores addr[1:0].
REQ-019 With MISALIGN_TRAP_EN: halfword at addr[0]=1 or word at addr[1:0]!=00 issues no request, causes no stall, loads a bubble (RegWriteW=0), and pulses outputs MisalignW=1 (1 bit) and MisalignAddrW=ALUResultM (32 bits) for one cycle; both outputs are reset to 0 and exist only when the macro is defined.

Verification
REQ-020 Zero-wait lw: ALUResultM=0x100, ResultSrcM=01, Funct3M=010, dmem_rdata=0xDEADBEEF, ack same cycle -> StallM=0, next cycle ReadDataW=0xDEADBEEF, RegWriteW=1.
REQ-021 3-wait-state lb at addr 0x103, rdata=0x80FF_FFFF -> StallM=1 for 3 cycles, req/addr=0x100 stable, 3 bubbles, then ReadDataW=0xFFFFFF80.
REQ-022 sh at addr 0x202, WriteDataM=0x1234ABCD -> dmem_addr=0x200, dmem_wdata=0xABCDABCD, dmem_be=1100, dmem_we=1, RegWriteW=0 after ack.
REQ-023 Reset asserted in WAIT, then spurious ack after release -> req drops immediately, W outputs 0, state stays IDLE.
REQ-024 ALU op (ResultSrcM=00, ALUResultM=7, RDM=5) -> no req, next cycle ALUResultW=7, RDW=5.
REQ-025 MISALIGN_TRAP_EN, lw at 0x102 -> no req, MisalignW=1 and MisalignAddrW=0x102 for one cycle, RegWriteW=0; without macro -> req at 0x100, be=1111.
